hash_vector_driver: RTL and testbench



---
 rtl/micro_ucr_pkg.sv | 23 ++
 rtl/hash_vector_driver_if.sv | 24 ++
 rtl/hash_vector_driver_mem.sv | 31 +++
 rtl/hash_vector_driver.sv | 145 ++++++++++++++
 tb/tb_hash_vector_driver.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/micro_ucr_pkg.sv
// Shared definitions for the micro_ucr hash core and its vector driver.
// State encoding, default widths and a byte-lane helper.
package micro_ucr_pkg;

  localparam int MSG_BYTES_DEF  = 16;
  localparam int HASH_BYTES_DEF = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } drv_state_t;

  function automatic logic [7:0] byte_lane(
    input logic [8*MSG_BYTES_DEF-1:0] v,
    input int unsigned                i
  );
    return v[8*i +: 8];
  endfunction

endpackage

// File: rtl/hash_vector_driver_if.sv
// Message/hash handshake between the vector driver and the hash core.
// The driver is the master, the core the slave.
interface hash_core_if
  import micro_ucr_pkg::*;
#(
  parameter int MSG_BYTES  = MSG_BYTES_DEF,
  parameter int HASH_BYTES = HASH_BYTES_DEF
);
  logic [8*MSG_BYTES-1:0]  msg_out;
  logic                    msg_valid;
  logic                    msg_ready;
  logic [8*HASH_BYTES-1:0] hash_in;
  logic                    hash_valid;

  modport master (
    output msg_out, msg_valid,
    input  msg_ready, hash_in, hash_valid
  );

  modport slave (
    input  msg_out, msg_valid,
    output msg_ready, hash_in, hash_valid
  );
endinterface

// File: rtl/hash_vector_driver_mem.sv
// Vector store: message and expected hash per entry.
// Synchronous write, asynchronous read, no reset.
module hash_vec_mem #(
  parameter int DEPTH = 8,
  parameter int MW    = 128,
  parameter int HW    = 24,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [MW-1:0] i_wmsg,
  input  logic [HW-1:0] i_wexp,
  input  logic [AW-1:0] i_msg_addr,
  output logic [MW-1:0] o_msg,
  input  logic [AW-1:0] i_exp_addr,
  output logic [HW-1:0] o_exp
);
  logic [MW-1:0] r_msg [DEPTH];
  logic [HW-1:0] r_exp [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_msg[i_waddr] <= i_wmsg;
      r_exp[i_waddr] <= i_wexp;
    end
  end

  assign o_msg = r_msg[i_msg_addr];
  assign o_exp = r_exp[i_exp_addr];
endmodule

// File: rtl/hash_vector_driver.sv
// Plays stored message vectors into the hash core and checks each
// returned hash against its expected value.
module hash_vector_driver
  import micro_ucr_pkg::*;
#(
  parameter int MSG_BYTES  = MSG_BYTES_DEF,
  parameter int HASH_BYTES = HASH_BYTES_DEF,
  parameter int DEPTH      = 8,
  parameter int LAT_MAX    = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int MW = 8 * MSG_BYTES,
  localparam int HW = 8 * HASH_BYTES,
  localparam int TW = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [MW-1:0] load_msg,
  input  logic [HW-1:0] load_exp,
  input  logic          start,
  input  logic [CW-1:0] num_vec,
  hash_core_if.master   core,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pass_count,
  output logic [CW-1:0] fail_count,
  output logic [AW-1:0] first_fail_idx,
  output logic          timeout_flag
);
  drv_state_t    r_state, w_next;
  logic [CW-1:0] r_n, r_pass, r_fail, w_n_start;
  logic [AW-1:0] r_idx, r_first, w_msg_addr;
  logic [TW-1:0] r_timer;
  logic [HW-1:0] r_hash, w_exp;
  logic [MW-1:0] r_msg, w_rd_msg;
  logic          r_tmo;
  logic          w_we, w_hs, w_tmo, w_last, w_empty;

  // Loads are only accepted while idle so a run sees a frozen store.
  assign w_we = load_en & (r_state == S_IDLE)
              & ({1'b0, load_addr} < (AW+1)'(DEPTH));
  assign w_n_start = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
  assign w_empty = (w_n_start == '0);
  assign w_hs = (r_state == S_ISSUE) & core.msg_ready;
  assign w_tmo = (r_state == S_WAIT) & ~core.hash_valid
               & (r_timer == TW'(LAT_MAX - 1));
  assign w_last = (CW'(r_idx) == r_n - CW'(1));
  assign w_msg_addr = (r_state == S_CHECK) ? r_idx + AW'(1) : '0;

  hash_vec_mem #(
    .DEPTH(DEPTH), .MW(MW), .HW(HW), .AW(AW)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (load_addr),
    .i_wmsg    (load_msg),
    .i_wexp    (load_exp),
    .i_msg_addr(w_msg_addr),
    .o_msg     (w_rd_msg),
    .i_exp_addr(r_idx),
    .o_exp     (w_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = w_empty ? S_DONE : S_ISSUE;
      S_ISSUE: if (w_hs) w_next = S_WAIT;
      S_WAIT: begin
        if (core.hash_valid) w_next = S_CHECK;
        else if (w_tmo)      w_next = S_DONE;
      end
      S_CHECK: w_next = w_last ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n     <= '0;
      r_idx   <= '0;
      r_timer <= '0;
      r_hash  <= '0;
      r_msg   <= '0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_first <= '0;
      r_tmo   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) begin
          r_n     <= w_n_start;
          r_idx   <= '0;
          r_pass  <= '0;
          r_fail  <= '0;
          r_first <= '0;
          r_tmo   <= 1'b0;
          if (!w_empty) r_msg <= w_rd_msg;
        end
        S_ISSUE: if (w_hs) r_timer <= '0;
        S_WAIT: begin
          if (core.hash_valid) begin
            r_hash <= core.hash_in;
          end else if (w_tmo) begin
            r_tmo  <= 1'b1;
            r_fail <= r_fail + CW'(1);
            if (r_fail == '0) r_first <= r_idx;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_CHECK: begin
          if (r_hash == w_exp) begin
            r_pass <= r_pass + CW'(1);
          end else begin
            r_fail <= r_fail + CW'(1);
            if (r_fail == '0) r_first <= r_idx;
          end
          if (!w_last) begin
            r_idx <= r_idx + AW'(1);
            r_msg <= w_rd_msg;
          end
        end
        default: ;
      endcase
    end
  end

  assign core.msg_out   = r_msg;
  assign core.msg_valid = (r_state == S_ISSUE);
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign pass_count     = r_pass;
  assign fail_count     = r_fail;
  assign first_fail_idx = r_first;
  assign timeout_flag   = r_tmo;
endmodule

// File: tb/tb_hash_vector_driver.sv
// Bench for hash_vector_driver: a behavioural hash core plus a
// run-level reference model of expected counts and latency.
module tb_hash_vector_driver;
  import micro_ucr_pkg::*;

  localparam int DEPTH = 8;
  localparam int LAT   = 64;
  localparam int AW    = 3;
  localparam int CW    = 4;
  localparam int MW    = 128;
  localparam int HW    = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [MW-1:0] load_msg;
  logic [HW-1:0] load_exp;
  logic          start;
  logic [CW-1:0] num_vec;
  logic          busy, done, timeout_flag;
  logic [CW-1:0] pass_count, fail_count;
  logic [AW-1:0] first_fail_idx;

  hash_core_if #(.MSG_BYTES(16), .HASH_BYTES(3)) bus ();

  hash_vector_driver #(
    .MSG_BYTES(16), .HASH_BYTES(3), .DEPTH(DEPTH), .LAT_MAX(LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .load_addr     (load_addr),
    .load_msg      (load_msg),
    .load_exp      (load_exp),
    .start         (start),
    .num_vec       (num_vec),
    .core          (bus),
    .busy          (busy),
    .done          (done),
    .pass_count    (pass_count),
    .fail_count    (fail_count),
    .first_fail_idx(first_fail_idx),
    .timeout_flag  (timeout_flag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  logic [MW-1:0] m_msg [DEPTH];
  logic [HW-1:0] m_exp [DEPTH];

  function automatic logic [HW-1:0] core_hash(input logic [MW-1:0] m);
    return {byte_lane(m, 2), byte_lane(m, 1), byte_lane(m, 0)};
  endfunction

  // Behavioural core: optional stall, hash 3 cycles after handshake.
  int stall_n  = 0;
  bit never_hv = 0;
  int hs_cnt   = 0;

  initial begin
    int cd, st;
    logic [MW-1:0] held, held_hs;
    cd = -1; st = 0; held = '0; held_hs = '0;
    bus.msg_ready  = 1'b0;
    bus.hash_valid = 1'b0;
    bus.hash_in    = '0;
    forever begin
      @(negedge clk);
      bus.hash_valid = 1'b0;
      bus.msg_ready  = 1'b0;
      if (reset) begin
        cd = -1; st = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.hash_valid = !never_hv;
            bus.hash_in    = core_hash(held_hs);
          end
        end
        if (bus.msg_valid) begin
          if (st < stall_n) begin
            if (st == 0) held = bus.msg_out;
            else chk("stall_msg", bus.msg_out, held);
            st++;
          end else begin
            bus.msg_ready = 1'b1;
            st = 0;
            held_hs = bus.msg_out;
            if (hs_cnt < DEPTH) chk("msg_out", bus.msg_out, m_msg[hs_cnt]);
            hs_cnt++;
            cd = 3;
          end
        end
      end
    end
  end

  task automatic load(input int a, input logic [MW-1:0] m,
                      input logic [HW-1:0] e);
    @(negedge clk);
    load_en = 1'b1; load_addr = AW'(a); load_msg = m; load_exp = e;
    @(negedge clk);
    load_en = 1'b0;
    m_msg[a] = m; m_exp[a] = e;
  endtask

  task automatic run(input int nv, input int stall, input bit never,
                     input bit poke, input string tag);
    int n, e_pass, e_fail, e_first, e_cyc, e_hs, cyc;
    bit e_tmo;
    n = (nv > DEPTH) ? DEPTH : nv;
    e_pass = 0; e_fail = 0; e_first = 0; e_tmo = 0; e_cyc = 1; e_hs = 0;
    for (int k = 0; k < n; k++) begin
      e_hs++;
      if (never) begin
        e_fail = 1; e_tmo = 1; e_first = k;
        e_cyc += stall + 1 + LAT;
        break;
      end
      e_cyc += stall + 1 + 3 + 1;
      if (core_hash(m_msg[k]) == m_exp[k]) e_pass++;
      else begin
        if (e_fail == 0) e_first = k;
        e_fail++;
      end
    end
    stall_n = stall; never_hv = never; hs_cnt = 0;
    @(negedge clk);
    start = 1'b1; num_vec = CW'(nv);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk({tag, "_busy1"}, busy, 1'b1);
    chk({tag, "_valid1"}, bus.msg_valid, n > 0);
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (poke && cyc == 3) begin
        start = 1'b1; num_vec = 4'd1;
        load_en = 1'b1; load_addr = '0;
        load_msg = {$urandom, $urandom, $urandom, $urandom};
        load_exp = HW'($urandom);
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, done, 1'b1);
    chk({tag, "_latency"}, cyc, e_cyc);
    chk({tag, "_pass"}, pass_count, e_pass);
    chk({tag, "_fail"}, fail_count, e_fail);
    chk({tag, "_first"}, first_fail_idx, e_first);
    chk({tag, "_tmo"}, timeout_flag, e_tmo);
    chk({tag, "_nvec"}, hs_cnt, e_hs);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_done"}, done, 1'b0);
    chk({tag, "_hold_pass"}, pass_count, e_pass);
    never_hv = 0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_mvalid"}, bus.msg_valid, 1'b0);
    chk({tag, "_mout"}, bus.msg_out, '0);
    chk({tag, "_pass"}, pass_count, '0);
    chk({tag, "_fail"}, fail_count, '0);
    chk({tag, "_first"}, first_fail_idx, '0);
    chk({tag, "_tmo"}, timeout_flag, 1'b0);
  endtask

  initial begin
    logic [MW-1:0] m;
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_msg = '0;
    load_exp = '0; start = 1'b0; num_vec = '0;
    repeat (3) @(negedge clk);
    chk_reset_outs("por");
    reset = 1'b0;

    load(0, 128'h3C87EDFD24331F6B6C9ECA402F9F7D39, 24'h9F7D39);
    run(1, 0, 0, 0, "basic");

    for (int k = 0; k < 4; k++)
      load(k, {16{8'h61}}, (k == 2) ? 24'h000000 : 24'h616161);
    run(4, 0, 0, 0, "failcont");

    load(0, 128'h3C87EDFD24331F6B6C9ECA402F9F7D39, 24'h9F7D39);
    run(1, 5, 0, 0, "bp");
    run(1, 0, 1, 0, "timeout");
    run(0, 0, 0, 0, "nv0");

    for (int k = 0; k < DEPTH; k++) begin
      m = {$urandom, $urandom, $urandom, $urandom};
      load(k, m, ($urandom_range(0, 1) == 1) ? core_hash(m) : HW'($urandom));
    end
    run(15, 0, 0, 0, "nv15");
    run(8, 1, 0, 1, "poke");

    run(4, 0, 0, 0, "prerst");
    stall_n = 0; hs_cnt = 0;
    @(negedge clk);
    start = 1'b1; num_vec = 4'd4;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 100 && hs_cnt < 2; k++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_reach_v1", hs_cnt >= 2, 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 chk_reset_outs("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run(4, 0, 0, 0, "postrst");

    for (int it = 0; it < 10; it++) begin
      for (int k = 0; k < DEPTH; k++) begin
        m = {$urandom, $urandom, $urandom, $urandom};
        load(k, m, ($urandom_range(0, 1) == 1) ? core_hash(m) : HW'($urandom));
      end
      run($urandom_range(0, 15), $urandom_range(0, 2), 0, 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
